// File: rtl/packet_reassembly_buffer.sv
// Multi-slot NoC packet reassembly: out-of-order flits are gathered per packet id,
// completed packets are queued and replayed as an in-order flit stream.
//
// state       | meaning
// ST_FREE     | slot unused, available for allocation
// ST_FILLING  | collecting flits, inactivity timer running
// ST_COMPLETE | all flits present, index waiting in the completion FIFO
// ST_DRAINING | being streamed out on out_*
module packet_reassembly_buffer #(
    parameter int NUM_ENTRIES   = 8,
    parameter int MAX_FLITS     = 8,
    parameter int FLIT_WIDTH    = 64,
    parameter int PID_WIDTH     = 8,
    parameter int EXPIRE_CYCLES = 100,
    localparam int IW = $clog2(MAX_FLITS),
    localparam int TW = $clog2(EXPIRE_CYCLES + 1),
    localparam int OW = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                  nocclk,
    input  logic                  rst,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic [PID_WIDTH-1:0]  in_packet_id,
    input  logic [IW-1:0]         in_flit_idx,
    input  logic                  in_is_tail,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic [PID_WIDTH-1:0]  out_packet_id,
    output logic                  out_is_tail,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  drop_pulse,
    output logic                  err_pulse,
    output logic [OW-1:0]         occupancy
);

    localparam int EW = $clog2(NUM_ENTRIES);
    localparam int CW = IW + 1;

    localparam logic [1:0] ST_FREE     = 2'd0;
    localparam logic [1:0] ST_FILLING  = 2'd1;
    localparam logic [1:0] ST_COMPLETE = 2'd2;
    localparam logic [1:0] ST_DRAINING = 2'd3;

    localparam logic [TW-1:0] TIMER_LIM = TW'(EXPIRE_CYCLES - 1);

    logic [1:0]            st_q    [NUM_ENTRIES];
    logic [1:0]            st_d    [NUM_ENTRIES];
    logic [PID_WIDTH-1:0]  pid_q   [NUM_ENTRIES];
    logic [PID_WIDTH-1:0]  pid_d   [NUM_ENTRIES];
    logic [MAX_FLITS-1:0]  mask_q  [NUM_ENTRIES];
    logic [MAX_FLITS-1:0]  mask_d  [NUM_ENTRIES];
    logic [CW-1:0]         total_q [NUM_ENTRIES];
    logic [CW-1:0]         total_d [NUM_ENTRIES];
    logic                  tail_q  [NUM_ENTRIES];
    logic                  tail_d  [NUM_ENTRIES];
    logic [TW-1:0]         timer_q [NUM_ENTRIES];
    logic [TW-1:0]         timer_d [NUM_ENTRIES];
    logic [FLIT_WIDTH-1:0] data_q  [NUM_ENTRIES][MAX_FLITS];

    logic [EW-1:0] fifo_q [NUM_ENTRIES];
    logic [EW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [OW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic                  out_valid_q, out_valid_d;
    logic [FLIT_WIDTH-1:0] out_flit_q, out_flit_d;
    logic [PID_WIDTH-1:0]  out_pid_q, out_pid_d;
    logic                  out_tail_q, out_tail_d;
    logic [EW-1:0]         drn_ent_q, drn_ent_d;
    logic [IW-1:0]         drn_idx_q, drn_idx_d;

    logic          drop_q, drop_d, err_q, err_d;
    logic [OW-1:0] occ_q, occ_d;

    logic                   match_any, free_any, cmp_any, exp_any;
    logic [EW-1:0]          match_idx, free_idx, cmp_idx, exp_idx, tgt, pop_ent;
    logic [NUM_ENTRIES-1:0] done;
    logic [IW-1:0]          hi_idx, drn_nidx;
    logic [CW-1:0]          tail_total;
    logic                   illegal, accept, wr_ok, pop, hs;

    function automatic logic [MAX_FLITS-1:0] low_mask(input logic [CW-1:0] n);
        logic [MAX_FLITS-1:0] m;
        for (int i = 0; i < MAX_FLITS; i++) m[i] = (CW'(i) < n);
        return m;
    endfunction

    function automatic logic [EW-1:0] ptr_inc(input logic [EW-1:0] p);
        return (p == EW'(NUM_ENTRIES - 1)) ? '0 : p + EW'(1);
    endfunction

    // Completion is judged on registered state, one cycle after the final write.
    always_comb begin
        done = '0;
        for (int e = 0; e < NUM_ENTRIES; e++)
            done[e] = (st_q[e] == ST_FILLING) && tail_q[e] && (mask_q[e] == low_mask(total_q[e]));
    end

    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        free_any  = 1'b0;
        free_idx  = '0;
        cmp_any   = 1'b0;
        cmp_idx   = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (st_q[e] == ST_FILLING && pid_q[e] == in_packet_id) begin
                match_any = 1'b1;
                match_idx = EW'(e);
            end
            if (st_q[e] == ST_FREE) begin
                free_any = 1'b1;
                free_idx = EW'(e);
            end
            if (done[e]) begin
                cmp_any = 1'b1;
                cmp_idx = EW'(e);
            end
        end
    end

    always_comb begin
        hi_idx = '0;
        for (int i = 0; i < MAX_FLITS; i++)
            if (mask_q[match_idx][i]) hi_idx = IW'(i);
    end

    assign in_ready   = match_any || free_any;
    assign accept     = in_valid && in_ready;
    assign tgt        = match_any ? match_idx : free_idx;
    assign tail_total = CW'(in_flit_idx) + CW'(1);
    assign illegal    = match_any &&
                        (mask_q[match_idx][in_flit_idx] ||
                         (tail_q[match_idx] && CW'(in_flit_idx) >= total_q[match_idx]) ||
                         (in_is_tail && in_flit_idx < hi_idx));
    assign wr_ok      = accept && !illegal;

    // An entry accepting a flit this cycle is never the one that expires.
    always_comb begin
        exp_any = 1'b0;
        exp_idx = '0;
        for (int e = NUM_ENTRIES - 1; e >= 0; e--) begin
            if (st_q[e] == ST_FILLING && timer_q[e] == TIMER_LIM && !done[e] &&
                !(accept && tgt == EW'(e))) begin
                exp_any = 1'b1;
                exp_idx = EW'(e);
            end
        end
    end

    assign pop      = !out_valid_q && (fifo_cnt_q != '0);
    assign pop_ent  = fifo_q[fifo_rd_q];
    assign hs       = out_valid_q && out_ready;
    assign drn_nidx = drn_idx_q + IW'(1);

    always_comb begin
        st_d    = st_q;
        pid_d   = pid_q;
        mask_d  = mask_q;
        total_d = total_q;
        tail_d  = tail_q;
        timer_d = timer_q;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (st_q[e] == ST_FILLING && timer_q[e] != TIMER_LIM)
                timer_d[e] = timer_q[e] + TW'(1);
            if (accept && tgt == EW'(e)) begin
                timer_d[e] = '0;
                if (!match_any) begin
                    st_d[e]    = ST_FILLING;
                    pid_d[e]   = in_packet_id;
                    mask_d[e]  = MAX_FLITS'(1) << in_flit_idx;
                    tail_d[e]  = in_is_tail;
                    total_d[e] = in_is_tail ? tail_total : '0;
                end else if (!illegal) begin
                    mask_d[e] = mask_q[e] | (MAX_FLITS'(1) << in_flit_idx);
                    if (in_is_tail) begin
                        tail_d[e]  = 1'b1;
                        total_d[e] = tail_total;
                    end
                end
            end
            if (cmp_any && cmp_idx == EW'(e))
                st_d[e] = ST_COMPLETE;
            if (exp_any && exp_idx == EW'(e))
                st_d[e] = ST_FREE;
            if (pop && pop_ent == EW'(e))
                st_d[e] = ST_DRAINING;
            if (hs && out_tail_q && drn_ent_q == EW'(e))
                st_d[e] = ST_FREE;
        end
    end

    always_comb begin
        fifo_wr_d  = cmp_any ? ptr_inc(fifo_wr_q) : fifo_wr_q;
        fifo_rd_d  = pop ? ptr_inc(fifo_rd_q) : fifo_rd_q;
        fifo_cnt_d = fifo_cnt_q;
        if (cmp_any && !pop)
            fifo_cnt_d = fifo_cnt_q + OW'(1);
        else if (!cmp_any && pop)
            fifo_cnt_d = fifo_cnt_q - OW'(1);
    end

    // A new packet is only fetched while the output register is empty, giving a
    // one-cycle bubble between packets.
    always_comb begin
        out_valid_d = out_valid_q;
        out_flit_d  = out_flit_q;
        out_pid_d   = out_pid_q;
        out_tail_d  = out_tail_q;
        drn_ent_d   = drn_ent_q;
        drn_idx_d   = drn_idx_q;
        if (pop) begin
            out_valid_d = 1'b1;
            out_flit_d  = data_q[pop_ent][0];
            out_pid_d   = pid_q[pop_ent];
            out_tail_d  = (total_q[pop_ent] == CW'(1));
            drn_ent_d   = pop_ent;
            drn_idx_d   = '0;
        end else if (hs) begin
            if (out_tail_q) begin
                out_valid_d = 1'b0;
                out_tail_d  = 1'b0;
            end else begin
                drn_idx_d  = drn_nidx;
                out_flit_d = data_q[drn_ent_q][drn_nidx];
                out_tail_d = (CW'(drn_nidx) + CW'(1) == total_q[drn_ent_q]);
            end
        end
    end

    always_comb begin
        occ_d = '0;
        for (int e = 0; e < NUM_ENTRIES; e++)
            if (st_d[e] != ST_FREE) occ_d = occ_d + OW'(1);
    end

    assign drop_d = exp_any;
    assign err_d  = accept && illegal;

    always_ff @(posedge nocclk) begin
        if (rst) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                st_q[e]    <= ST_FREE;
                pid_q[e]   <= '0;
                mask_q[e]  <= '0;
                total_q[e] <= '0;
                tail_q[e]  <= 1'b0;
                timer_q[e] <= '0;
            end
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
            fifo_cnt_q  <= '0;
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_pid_q   <= '0;
            out_tail_q  <= 1'b0;
            drn_ent_q   <= '0;
            drn_idx_q   <= '0;
            drop_q      <= 1'b0;
            err_q       <= 1'b0;
            occ_q       <= '0;
        end else begin
            st_q        <= st_d;
            pid_q       <= pid_d;
            mask_q      <= mask_d;
            total_q     <= total_d;
            tail_q      <= tail_d;
            timer_q     <= timer_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
            out_valid_q <= out_valid_d;
            out_flit_q  <= out_flit_d;
            out_pid_q   <= out_pid_d;
            out_tail_q  <= out_tail_d;
            drn_ent_q   <= drn_ent_d;
            drn_idx_q   <= drn_idx_d;
            drop_q      <= drop_d;
            err_q       <= err_d;
            occ_q       <= occ_d;
        end
    end

    // Payload and FIFO storage carry no control meaning, so they are not reset.
    always_ff @(posedge nocclk) begin
        if (wr_ok)
            data_q[tgt][in_flit_idx] <= in_flit;
        if (cmp_any)
            fifo_q[fifo_wr_q] <= cmp_idx;
    end

    assign out_valid     = out_valid_q;
    assign out_flit      = out_flit_q;
    assign out_packet_id = out_pid_q;
    assign out_is_tail   = out_tail_q;
    assign drop_pulse    = drop_q;
    assign err_pulse     = err_q;
    assign occupancy     = occ_q;

endmodule

// File: tb/tb_packet_reassembly_buffer.sv
// Directed bench for packet_reassembly_buffer: ordering, errors, full, expiry,
// back-pressure and mid-drain reset, each scenario with hand-computed expectations.
module tb_packet_reassembly_buffer;

    localparam int FW = 64;
    localparam int PW = 8;
    localparam int IW = 3;
    localparam int OW = 4;

    logic          nocclk = 1'b0;
    logic          rst = 1'b1;
    logic [FW-1:0] in_flit = '0;
    logic [PW-1:0] in_packet_id = '0;
    logic [IW-1:0] in_flit_idx = '0;
    logic          in_is_tail = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [FW-1:0] out_flit;
    logic [PW-1:0] out_packet_id;
    logic          out_is_tail;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          drop_pulse;
    logic          err_pulse;
    logic [OW-1:0] occupancy;

    int n_tests = 0;
    int n_fail  = 0;
    int err_cnt = 0;

    logic [PW-1:0] mon_pid[$];
    logic [FW-1:0] mon_flit[$];
    logic          mon_tail[$];

    packet_reassembly_buffer dut (
        .nocclk(nocclk), .rst(rst),
        .in_flit(in_flit), .in_packet_id(in_packet_id), .in_flit_idx(in_flit_idx),
        .in_is_tail(in_is_tail), .in_valid(in_valid), .in_ready(in_ready),
        .out_flit(out_flit), .out_packet_id(out_packet_id), .out_is_tail(out_is_tail),
        .out_valid(out_valid), .out_ready(out_ready),
        .drop_pulse(drop_pulse), .err_pulse(err_pulse), .occupancy(occupancy)
    );

    always #5 nocclk = ~nocclk;

    // Handshakes are recorded half a cycle before the edge that completes them.
    always @(negedge nocclk) begin
        if (!rst && out_valid && out_ready) begin
            mon_pid.push_back(out_packet_id);
            mon_flit.push_back(out_flit);
            mon_tail.push_back(out_is_tail);
        end
        if (!rst && err_pulse) err_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [FW-1:0] fd(input logic [PW-1:0] pid, input logic [IW-1:0] idx);
        return {32'hC0DE_F00D, 16'h0000, pid, 5'b00000, idx};
    endfunction

    task automatic step();
        @(posedge nocclk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] pid, input logic [IW-1:0] idx, input logic tail,
                        input logic [FW-1:0] d);
        in_valid     = 1'b1;
        in_packet_id = pid;
        in_flit_idx  = idx;
        in_is_tail   = tail;
        in_flit      = d;
        step();
        in_valid   = 1'b0;
        in_is_tail = 1'b0;
    endtask

    task automatic clear_mon();
        mon_pid.delete();
        mon_flit.delete();
        mon_tail.delete();
    endtask

    task automatic wait_out(input int n, output int got);
        int c = 0;
        while (mon_pid.size() < n && c < 300) begin
            step();
            c++;
        end
        got = mon_pid.size();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++;
        if ({out_valid, out_is_tail, drop_pulse, err_pulse} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got v/t/drop/err %b%b%b%b want 0000", out_valid, out_is_tail, drop_pulse, err_pulse);
        end
        n_tests++;
        if (out_flit !== '0 || out_packet_id !== '0) begin
            n_fail++;
            $display("FAIL reset_data: got flit %h pid %h want 0", out_flit, out_packet_id);
        end
        rst = 1'b0;
        step();
        n_tests++;
        if (occupancy !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_occ_ready: got occ %0d ready %b want 0 1", occupancy, in_ready);
        end
    endtask

    task automatic test_in_order();
        int got;
        clear_mon();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) send(8'h12, IW'(k), k == 3, fd(8'h12, IW'(k)));
        n_tests++;
        if (out_valid !== 1'b0 || occupancy !== 4'd1) begin
            n_fail++;
            $display("FAIL inorder_t0: got valid %b occ %0d want 0 1", out_valid, occupancy);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL inorder_t1: got valid %b want 0", out_valid);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b1 || out_flit !== fd(8'h12, 3'd0)) begin
            n_fail++;
            $display("FAIL inorder_t2: got valid %b flit %h want 1 %h", out_valid, out_flit, fd(8'h12, 3'd0));
        end
        wait_out(4, got);
        n_tests++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL inorder_count: got %0d flits want 4", got);
        end
        for (int k = 0; k < 4 && k < mon_pid.size(); k++) begin
            n_tests++;
            if ({mon_pid[k], mon_flit[k], mon_tail[k]} !== {8'h12, fd(8'h12, IW'(k)), k == 3}) begin
                n_fail++;
                $display("FAIL inorder_flit%0d: got pid %h data %h tail %b want pid 12 data %h tail %b",
                         k, mon_pid[k], mon_flit[k], mon_tail[k], fd(8'h12, IW'(k)), k == 3);
            end
        end
        n_tests++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL inorder_end: got valid %b occ %0d want 0 0", out_valid, occupancy);
        end
    endtask

    task automatic test_out_of_order();
        int got;
        int e0;
        clear_mon();
        e0 = err_cnt;
        send(8'h05, 3'd2, 1'b0, fd(8'h05, 3'd2));
        send(8'h05, 3'd0, 1'b0, fd(8'h05, 3'd0));
        send(8'h05, 3'd3, 1'b1, fd(8'h05, 3'd3));
        send(8'h05, 3'd1, 1'b0, fd(8'h05, 3'd1));
        wait_out(4, got);
        n_tests++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL ooo_count: got %0d flits want 4", got);
        end
        for (int k = 0; k < 4 && k < mon_pid.size(); k++) begin
            n_tests++;
            if ({mon_pid[k], mon_flit[k], mon_tail[k]} !== {8'h05, fd(8'h05, IW'(k)), k == 3}) begin
                n_fail++;
                $display("FAIL ooo_flit%0d: got pid %h data %h tail %b want pid 05 data %h tail %b",
                         k, mon_pid[k], mon_flit[k], mon_tail[k], fd(8'h05, IW'(k)), k == 3);
            end
        end
        n_tests++;
        if (err_cnt != e0) begin
            n_fail++;
            $display("FAIL ooo_err: got %0d error pulses want 0", err_cnt - e0);
        end
    endtask

    task automatic test_duplicate();
        int got;
        int e0;
        clear_mon();
        e0 = err_cnt;
        send(8'h07, 3'd0, 1'b0, fd(8'h07, 3'd0));
        send(8'h07, 3'd1, 1'b0, fd(8'h07, 3'd1));
        send(8'h07, 3'd1, 1'b0, 64'hDEAD_BEEF_DEAD_BEEF);
        n_tests++;
        if (err_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_err_hi: got %b want 1", err_pulse);
        end
        send(8'h07, 3'd2, 1'b1, fd(8'h07, 3'd2));
        n_tests++;
        if (err_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL dup_err_lo: got %b want 0", err_pulse);
        end
        wait_out(3, got);
        n_tests++;
        if (got != 3 || err_cnt - e0 != 1) begin
            n_fail++;
            $display("FAIL dup_count: got %0d flits %0d errs want 3 1", got, err_cnt - e0);
        end
        for (int k = 0; k < 3 && k < mon_pid.size(); k++) begin
            n_tests++;
            if ({mon_pid[k], mon_flit[k], mon_tail[k]} !== {8'h07, fd(8'h07, IW'(k)), k == 2}) begin
                n_fail++;
                $display("FAIL dup_flit%0d: got pid %h data %h tail %b want pid 07 data %h tail %b",
                         k, mon_pid[k], mon_flit[k], mon_tail[k], fd(8'h07, IW'(k)), k == 2);
            end
        end
    endtask

    task automatic test_illegal();
        int got;
        int e0;
        logic [PW-1:0] ep  [7] = '{8'h09, 8'h09, 8'h09, 8'h0A, 8'h0A, 8'h0A, 8'h0A};
        logic [IW-1:0] ei  [7] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3};
        logic          et  [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        clear_mon();
        e0 = err_cnt;
        send(8'h09, 3'd0, 1'b0, fd(8'h09, 3'd0));
        send(8'h09, 3'd2, 1'b1, fd(8'h09, 3'd2));
        send(8'h09, 3'd3, 1'b0, 64'h1111_2222_3333_4444);
        n_tests++;
        if (err_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_beyond_tail: got err %b want 1", err_pulse);
        end
        send(8'h09, 3'd1, 1'b0, fd(8'h09, 3'd1));
        send(8'h0A, 3'd2, 1'b0, fd(8'h0A, 3'd2));
        send(8'h0A, 3'd1, 1'b1, 64'h5555_6666_7777_8888);
        n_tests++;
        if (err_pulse !== 1'b1) begin
            n_fail++;
            $display("FAIL ill_early_tail: got err %b want 1", err_pulse);
        end
        send(8'h0A, 3'd0, 1'b0, fd(8'h0A, 3'd0));
        send(8'h0A, 3'd1, 1'b0, fd(8'h0A, 3'd1));
        send(8'h0A, 3'd3, 1'b1, fd(8'h0A, 3'd3));
        wait_out(7, got);
        n_tests++;
        if (got != 7 || err_cnt - e0 != 2) begin
            n_fail++;
            $display("FAIL ill_count: got %0d flits %0d errs want 7 2", got, err_cnt - e0);
        end
        for (int k = 0; k < 7 && k < mon_pid.size(); k++) begin
            n_tests++;
            if ({mon_pid[k], mon_flit[k], mon_tail[k]} !== {ep[k], fd(ep[k], ei[k]), et[k]}) begin
                n_fail++;
                $display("FAIL ill_flit%0d: got pid %h data %h tail %b want pid %h data %h tail %b",
                         k, mon_pid[k], mon_flit[k], mon_tail[k], ep[k], fd(ep[k], ei[k]), et[k]);
            end
        end
    endtask

    task automatic test_full();
        clear_mon();
        out_ready = 1'b1;
        for (int p = 0; p < 8; p++) send(PW'(p), 3'd0, 1'b0, fd(PW'(p), 3'd0));
        in_packet_id = 8'h08;
        #1;
        n_tests++;
        if (in_ready !== 1'b0 || occupancy !== 4'd8) begin
            n_fail++;
            $display("FAIL full_new_pid: got ready %b occ %0d want 0 8", in_ready, occupancy);
        end
        in_packet_id = 8'h03;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_match_pid: got ready %b want 1", in_ready);
        end
        send(8'h03, 3'd1, 1'b1, fd(8'h03, 3'd1));
        in_valid     = 1'b1;
        in_packet_id = 8'h08;
        in_flit_idx  = 3'd0;
        in_flit      = fd(8'h08, 3'd0);
        step();
        step();
        step();
        n_tests++;
        if (in_ready !== 1'b0 || occupancy !== 4'd8) begin
            n_fail++;
            $display("FAIL full_before_hs: got ready %b occ %0d want 0 8", in_ready, occupancy);
        end
        step();
        n_tests++;
        if (in_ready !== 1'b1 || occupancy !== 4'd7) begin
            n_fail++;
            $display("FAIL full_after_hs: got ready %b occ %0d want 1 7", in_ready, occupancy);
        end
        step();
        in_valid = 1'b0;
        n_tests++;
        if (occupancy !== 4'd8) begin
            n_fail++;
            $display("FAIL full_pid8_accept: got occ %0d want 8", occupancy);
        end
        n_tests++;
        if (mon_pid.size() != 2 || {mon_pid[0], mon_flit[0], mon_tail[0], mon_pid[1], mon_flit[1], mon_tail[1]}
            !== {8'h03, fd(8'h03, 3'd0), 1'b0, 8'h03, fd(8'h03, 3'd1), 1'b1}) begin
            n_fail++;
            $display("FAIL full_drain: got %0d flits want pid 03 idx 0,1 with tail on 2nd", mon_pid.size());
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_expire();
        int early;
        send(8'h20, 3'd0, 1'b0, fd(8'h20, 3'd0));
        early = 0;
        for (int k = 1; k < 100; k++) begin
            step();
            if (drop_pulse) early++;
        end
        n_tests++;
        if (early != 0 || occupancy !== 4'd1) begin
            n_fail++;
            $display("FAIL exp_early: got %0d early drops occ %0d want 0 1", early, occupancy);
        end
        step();
        n_tests++;
        if (drop_pulse !== 1'b1 || occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL exp_at_100: got drop %b occ %0d want 1 0", drop_pulse, occupancy);
        end
        step();
        n_tests++;
        if (drop_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL exp_pulse_len: got drop %b want 0", drop_pulse);
        end
        send(8'h21, 3'd0, 1'b0, fd(8'h21, 3'd0));
        repeat (98) step();
        send(8'h21, 3'd1, 1'b0, fd(8'h21, 3'd1));
        early = 0;
        for (int k = 100; k < 199; k++) begin
            step();
            if (drop_pulse) early++;
        end
        n_tests++;
        if (early != 0 || occupancy !== 4'd1) begin
            n_fail++;
            $display("FAIL exp_refresh: got %0d drops occ %0d want 0 1", early, occupancy);
        end
        step();
        n_tests++;
        if (drop_pulse !== 1'b1 || occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL exp_after_refresh: got drop %b occ %0d want 1 0", drop_pulse, occupancy);
        end
    endtask

    task automatic test_back_to_back();
        int got;
        int unstable;
        logic [PW-1:0] ep [4] = '{8'h40, 8'h40, 8'h40, 8'h41};
        logic [IW-1:0] ei [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
        logic          et [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        clear_mon();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(8'h40, IW'(k), k == 2, fd(8'h40, IW'(k)));
        send(8'h41, 3'd0, 1'b0, fd(8'h41, 3'd0));
        send(8'h41, 3'd1, 1'b1, fd(8'h41, 3'd1));
        unstable = 0;
        for (int k = 0; k < 20; k++) begin
            if (!out_valid || out_flit !== fd(8'h40, 3'd0) || out_packet_id !== 8'h40 || out_is_tail) unstable++;
            step();
        end
        n_tests++;
        if (unstable != 0 || occupancy !== 4'd2) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles occ %0d want 0 2", unstable, occupancy);
        end
        out_ready = 1'b1;
        wait_out(4, got);
        out_ready = 1'b0;
        n_tests++;
        if (got != 4) begin
            n_fail++;
            $display("FAIL bp_count: got %0d flits want 4", got);
        end
        for (int k = 0; k < 4 && k < mon_pid.size(); k++) begin
            n_tests++;
            if ({mon_pid[k], mon_flit[k], mon_tail[k]} !== {ep[k], fd(ep[k], ei[k]), et[k]}) begin
                n_fail++;
                $display("FAIL bp_flit%0d: got pid %h data %h tail %b want pid %h data %h tail %b",
                         k, mon_pid[k], mon_flit[k], mon_tail[k], ep[k], fd(ep[k], ei[k]), et[k]);
            end
        end
        n_tests++;
        if (out_valid !== 1'b1 || out_packet_id !== 8'h41 || out_flit !== fd(8'h41, 3'd1) || out_is_tail !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_mid_b: got valid %b pid %h flit %h tail %b want 1 41 %h 1",
                     out_valid, out_packet_id, out_flit, out_is_tail, fd(8'h41, 3'd1));
        end
        rst = 1'b1;
        step();
        n_tests++;
        if ({out_valid, out_is_tail, drop_pulse, err_pulse} !== 4'b0000 || out_flit !== '0 ||
            out_packet_id !== '0 || occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL bp_reset: got valid %b tail %b flit %h pid %h occ %0d want all 0",
                     out_valid, out_is_tail, out_flit, out_packet_id, occupancy);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        n_tests++;
        if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            n_fail++;
            $display("FAIL bp_after_reset: got valid %b occ %0d want 0 0", out_valid, occupancy);
        end
    endtask

    initial begin
        test_reset();
        test_in_order();
        test_out_of_order();
        test_duplicate();
        test_illegal();
        test_full();
        test_expire();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_reassembly_buffer.md
Name: packet_reassembly_buffer

Overview:
Parametrised multi-entry reassembly buffer for the NoC receive path. It collects flits of up to NUM_ENTRIES concurrent packets, keyed by packet id. Flits may arrive in any order. Each completed packet is emitted as an in-order flit stream over a valid/ready interface. Partial packets are discarded after a programmable inactivity timeout, and duplicate or illegal flits are discarded and reported.

Parameters:
NUM_ENTRIES, 8, number of concurrent packet slots (>=2)
MAX_FLITS, 8, maximum flits per packet (power of 2, >=2)
FLIT_WIDTH, 64, flit data width in bits
PID_WIDTH, 8, packet id width
EXPIRE_CYCLES, 100, inactivity cycles before a partial packet is dropped
(IW = $clog2(MAX_FLITS), TW = $clog2(EXPIRE_CYCLES+1), OW = $clog2(NUM_ENTRIES+1))

Ports:
nocclk  in  1  NoC clock
rst  in  1  synchronous active-high reset
in_flit  in  FLIT_WIDTH  incoming flit data
in_packet_id  in  PID_WIDTH  packet id of incoming flit
in_flit_idx  in  IW  position of flit within packet (head = 0)
in_is_tail  in  1  flit is last of packet
in_valid  in  1  input flit valid
in_ready  out  1  buffer can accept a flit this cycle
out_flit  out  FLIT_WIDTH  reassembled flit data
out_packet_id  out  PID_WIDTH  packet id of output flit
out_is_tail  out  1  last flit of output packet
out_valid  out  1  output flit valid
out_ready  in  1  downstream accepts output flit
drop_pulse  out  1  one-cycle pulse: partial packet expired
err_pulse  out  1  one-cycle pulse: duplicate/illegal flit discarded
occupancy  out  OW  number of non-FREE entries

Behaviour:
- Reset: all entries FREE, completion FIFO empty. out_valid, out_flit, out_packet_id, out_is_tail, drop_pulse and err_pulse are 0; occupancy is 0. A reset mid-operation discards all state, including a packet being drained.
- Entry states are FREE -> FILLING -> COMPLETE -> DRAINING -> FREE. Each entry holds: pid, MAX_FLITS data slots, received mask, total (valid once tail seen), tail_seen, and timer.
- Match uses in_packet_id against FILLING entries only. A pid equal to a COMPLETE or DRAINING entry allocates a new entry, because it is a new packet.
- in_ready = (a FILLING entry matches in_packet_id) OR (any FREE entry exists).
  - in_ready depends on current state and input fields, never on in_valid.
  - A FREE created this cycle (expiry or drain end) becomes visible next cycle.
- Accept (in_valid && in_ready):
  - If a match exists, write slot[in_flit_idx] and set its mask bit.
  - If no match, allocate the lowest-index FREE entry: store pid, clear mask, write the slot, set timer to 0.
  - If the mask bit is already set, OR tail_seen and idx >= total, OR in_is_tail and idx < highest received idx: discard the flit, assert err_pulse next cycle, leave the entry unchanged. Its timer is still reset.
  - A tail flit sets tail_seen and total = idx+1.
- Completion: when tail_seen and mask[total-1:0] is all ones after a write, the entry goes to COMPLETE on the next edge, and its index is pushed into an internal completion FIFO (depth NUM_ENTRIES, cannot overflow). A single flit with idx 0 and in_is_tail completes immediately.
- Timer:
  - While FILLING, the timer increments every cycle and resets to 0 on any accepted flit for that entry.
  - When the timer reaches EXPIRE_CYCLES-1 without an accept that cycle, the entry goes FREE and drop_pulse asserts for 1 cycle.
  - If an accept coincides with expiry, the accept wins and the timer resets.
  - Only one entry can expire per cycle. If several hit the limit together, the lowest index expires first; the others retain the limit value and expire in later cycles.
- Drain:
  - When idle and the FIFO is non-empty, pop the head entry, mark it DRAINING, and present slot 0.
  - out_* are registered. out_valid holds, and data is stable, until out_ready.
  - Each handshake advances idx; out_is_tail = 1 when idx = total-1.
  - On the tail handshake the entry goes FREE. The next FIFO entry may present on the following cycle, so there is no bubble beyond 1 cycle.
- Latency: last missing flit accepted at edge t -> COMPLETE at t+1 -> out_valid at t+2 if the drain is idle.
- occupancy = count of non-FREE entries, registered.
- Full: all entries non-FREE and no match -> in_ready = 0; drain and expiry still proceed.

Test Plan:
1. 4-flit pid 0x12, idx 0,1,2,3 (tail at 3), out_ready=1 -> out_valid 2 cycles after tail; 4 flits in order, out_is_tail on the 4th, occupancy 1 -> 0.
2. pid 0x05 flits sent as idx 2, 0, 3(tail), 1 -> output order idx 0,1,2,3 with matching data; err_pulse never asserts.
3. idx 1 of pid 0x07 sent twice -> second copy discarded, err_pulse = 1 for 1 cycle, output still 3 correct flits (total 3).
4. NUM_ENTRIES=8: open 8 partial packets, pid 0..7 -> in_ready=0 for new pid 8, in_ready=1 for a flit of pid 3; complete pid 3 and drain it -> pid 8 accepted the cycle after the tail handshake.
5. EXPIRE_CYCLES=100: send only idx 0 of pid 0x20, then idle -> drop_pulse exactly 100 cycles after accept, occupancy returns to 0. Repeat with a flit at cycle 99 -> no drop.
6. Complete pid A then pid B while out_ready=0 for 20 cycles -> out_flit stable and no loss; A fully drained before B. Assert rst mid-B -> all outputs 0 next cycle, occupancy 0.
